// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed driver for a 4-digit common-anode seven-segment display.
// Each digit slot is an all-off blanking gap followed by the lit digit.
// Bus writes land in a pending buffer. The pending buffer is copied into the
// display buffer only when digit 0 starts, so one frame never mixes two values.
// All pin drives are registered and change on the same edge as the scan state.

module seg7_scan_driver #(
  parameter int SCAN_DIV  = 50000, // cycles a digit is lit, >= 2
  parameter int BLANK_CYC = 16     // cycles of all-off before each digit, >= 1
) (
  input  logic        clk_100mhz,
  input  logic        rst,         // synchronous, active-low
  input  logic        wr,
  input  logic [15:0] wr_value,
  input  logic [3:0]  wr_dp,
  input  logic [3:0]  wr_blank,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  // One counter serves both phases, so it is sized for the longer phase.
  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);

  // Scan phases
  localparam logic [0:0] ST_BLANK = 1'b0;
  localparam logic [0:0] ST_SHOW  = 1'b1;

  // Scan sequencer
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [1:0]       idx_q,   idx_d;

  // Bus-side pending buffer
  logic [15:0] pend_value_q, pend_value_d;
  logic [3:0]  pend_dp_q,    pend_dp_d;
  logic [3:0]  pend_blank_q, pend_blank_d;

  // Frame-stable display buffer
  logic [15:0] disp_value_q, disp_value_d;
  logic [3:0]  disp_dp_q,    disp_dp_d;
  logic [3:0]  disp_blank_q, disp_blank_d;

  // Registered pin drives
  logic [7:0] seg_q,  seg_d;
  logic [3:0] an_q,   an_d;
  logic       tick_q, tick_d;

  // Per-digit drive patterns, decoded from the buffer that will be in effect
  // after the coming edge
  logic [7:0] digit_seg [4];
  logic [3:0] digit_an  [4];
  logic       digit_lit [4];

  // Hex to active-low segments, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Decode each digit position once; the output mux just picks one
  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign digit_seg[gi] = {~disp_dp_d[gi], hex7(disp_value_d[gi*4 +: 4])};
    assign digit_an[gi]  = ~(4'b0001 << gi);
    assign digit_lit[gi] = ~disp_blank_d[gi];
  end

  // Phase sequencing, write capture and frame-start reload of the display buffer
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    tick_d       = 1'b0;

    pend_value_d = pend_value_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    if (wr) begin
      pend_value_d = wr_value;
      pend_dp_d    = wr_dp;
      pend_blank_d = wr_blank;
    end

    disp_value_d = disp_value_q;
    disp_dp_d    = disp_dp_q;
    disp_blank_d = disp_blank_q;

    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
          if (idx_q == 2'd0) begin
            // Frame start: a write on this very edge goes straight through,
            // otherwise the last write seen since the previous frame is used.
            tick_d       = 1'b1;
            disp_value_d = pend_value_d;
            disp_dp_d    = pend_dp_d;
            disp_blank_d = pend_blank_d;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (cnt_q == SHOW_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = idx_q + 2'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  // Pin drive for the state being entered, so the pins switch with the state
  always_comb begin
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (state_d == ST_SHOW && digit_lit[idx_d]) begin
      an_d  = digit_an[idx_d];
      seg_d = digit_seg[idx_d];
    end
  end

  // Scan sequencer registers; reset restarts in blanking at digit 0
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Pending and display buffers; both cleared by reset
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      pend_value_q <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= '0;
      disp_value_q <= '0;
      disp_dp_q    <= '0;
      disp_blank_q <= '0;
    end else begin
      pend_value_q <= pend_value_d;
      pend_dp_q    <= pend_dp_d;
      pend_blank_q <= pend_blank_d;
      disp_value_q <= disp_value_d;
      disp_dp_q    <= disp_dp_d;
      disp_blank_q <= disp_blank_d;
    end
  end

  // Output registers; display goes dark on the reset edge itself
  always_ff @(posedge clk_100mhz) begin
    if (!rst) begin
      an_q   <= 4'hF;
      seg_q  <= 8'hFF;
      tick_q <= 1'b0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      tick_q <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Directed bench for seg7_scan_driver with SCAN_DIV=4, BLANK_CYC=2
// (digit period 6 cycles, frame 24 cycles, frame_tick at frame cycle 0).

module tb_seg7_scan_driver;
  localparam int SCAN_DIV  = 4;
  localparam int BLANK_CYC = 2;

  logic        clk_100mhz = 1'b0;
  logic        rst;
  logic        wr;
  logic [15:0] wr_value;
  logic [3:0]  wr_dp;
  logic [3:0]  wr_blank;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks   = 0;
  int failures = 0;

  seg7_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) dut (
    .clk_100mhz(clk_100mhz),
    .rst       (rst),
    .wr        (wr),
    .wr_value  (wr_value),
    .wr_dp     (wr_dp),
    .wr_blank  (wr_blank),
    .seg       (seg),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  // One write and the frame it must produce: segs = {d3,d2,d1,d0}, ans likewise
  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [31:0] segs;
    logic [15:0] ans;
  } vec_t;

  vec_t vecs [6];

  task automatic step();
    @(posedge clk_100mhz);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected pins at frame cycle c (0 = frame_tick cycle)
  task automatic check_cycle(input int c, input logic [31:0] segs, input logic [15:0] ans,
                             input string name);
    int d = c / 6;
    int p = c % 6;
    logic [3:0] ea;
    logic [7:0] es;
    if (p < 4) begin
      ea = ans[d*4 +: 4];
      es = segs[d*8 +: 8];
    end else begin
      ea = 4'hF;
      es = 8'hFF;
    end
    chk($sformatf("%s c%0d an", name, c), 32'(an), 32'(ea));
    chk($sformatf("%s c%0d seg", name, c), 32'(seg), 32'(es));
    chk($sformatf("%s c%0d tick", name, c), 32'(frame_tick), (c == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_range(input int from, input int to, input logic [31:0] segs,
                             input logic [15:0] ans, input string name);
    for (int c = from; c <= to; c++) begin
      check_cycle(c, segs, ans, name);
      if (c < to) step();
    end
  endtask

  // Checks a whole frame starting at its tick cycle; ends on the next tick cycle
  task automatic check_frame(input logic [31:0] segs, input logic [15:0] ans, input string name);
    check_range(0, 23, segs, ans, name);
    step();
    chk({name, " period"}, 32'(frame_tick), 32'd1);
  endtask

  task automatic wait_tick(input string name);
    int n = 0;
    while (frame_tick !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk({name, " tick seen"}, 32'(frame_tick), 32'd1);
  endtask

  task automatic do_write(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl);
    wr       = 1'b1;
    wr_value = v;
    wr_dp    = dp;
    wr_blank = bl;
    step();
    wr       = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h12AF, 4'b0000, 4'b0000, 32'hF9A4888E, 16'h7BDE};
    vecs[1] = '{16'h12AF, 4'b0100, 4'b0000, 32'hF924888E, 16'h7BDE};
    vecs[2] = '{16'h12AF, 4'b0000, 4'b1000, 32'hFFA4888E, 16'hFBDE};
    vecs[3] = '{16'h0000, 4'b0000, 4'b0000, 32'hC0C0C0C0, 16'h7BDE};
    vecs[4] = '{16'h3B7D, 4'b1001, 4'b0010, 32'h3083FF21, 16'h7BFE};
    vecs[5] = '{16'hC6E4, 4'b0000, 4'b0000, 32'hC6828699, 16'h7BDE};

    rst      = 1'b0;
    wr       = 1'b0;
    wr_value = '0;
    wr_dp    = '0;
    wr_blank = '0;

    // Reset held for three cycles
    repeat (3) step();
    chk("reset an", 32'(an), 32'h0000000F);
    chk("reset seg", 32'(seg), 32'h000000FF);
    chk("reset tick", 32'(frame_tick), 32'd0);
    $display("reset: an=%h seg=%h tick=%b", an, seg, frame_tick);

    // Release: one more blank cycle, then digit 0 of a cleared display
    rst = 1'b1;
    step();
    chk("release blank an", 32'(an), 32'h0000000F);
    chk("release blank seg", 32'(seg), 32'h000000FF);
    chk("release blank tick", 32'(frame_tick), 32'd0);
    step();
    check_frame(32'hC0C0C0C0, 16'h7BDE, "frame0");

    // Table-driven: write during a frame, the following frame shows it
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].value, vecs[i].dp, vecs[i].blank);
      wait_tick($sformatf("vec%0d", i));
      check_frame(vecs[i].segs, vecs[i].ans, $sformatf("vec%0d", i));
      $display("vec %0d: value=%h dp=%b blank=%b checked", i, vecs[i].value, vecs[i].dp, vecs[i].blank);
    end

    // Tearing: a 0000 frame, write 8888 during digit 1; digits 2,3 keep C0
    do_write(16'h0000, 4'b0000, 4'b0000);
    wait_tick("tear setup");
    repeat (7) step();
    do_write(16'h8888, 4'b0000, 4'b0000);
    check_range(8, 23, 32'hC0C0C0C0, 16'h7BDE, "tear");
    step();
    chk("tear next tick", 32'(frame_tick), 32'd1);
    check_frame(32'h80808080, 16'h7BDE, "tear next");
    $display("tearing: mid-frame write deferred to next frame");

    // Bypass: write landing on the frame-start edge is shown in that frame
    repeat (23) step();
    do_write(16'h5555, 4'b0000, 4'b0000);
    check_frame(32'h92929292, 16'h7BDE, "bypass");
    check_frame(32'h92929292, 16'h7BDE, "bypass hold");
    $display("bypass: write on frame-start edge shown immediately");

    // Back-to-back writes: last one wins
    do_write(16'h1111, 4'b0000, 4'b0000);
    do_write(16'h2222, 4'b0000, 4'b0000);
    wait_tick("lastwr");
    check_frame(32'hA4A4A4A4, 16'h7BDE, "lastwr");
    $display("back-to-back writes: last value shown");

    // Reset during digit-2 SHOW
    repeat (13) step();
    chk("pre-reset an", 32'(an), 32'h0000000B);
    rst = 1'b0;
    step();
    chk("midreset an", 32'(an), 32'h0000000F);
    chk("midreset seg", 32'(seg), 32'h000000FF);
    chk("midreset tick", 32'(frame_tick), 32'd0);
    step();
    chk("midreset hold an", 32'(an), 32'h0000000F);
    rst = 1'b1;
    step();
    chk("midreset release an", 32'(an), 32'h0000000F);
    chk("midreset release seg", 32'(seg), 32'h000000FF);
    step();
    check_frame(32'hC0C0C0C0, 16'h7BDE, "after reset");
    $display("mid-scan reset: restarted at digit 0 with cleared display");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
